// File: rtl/auto_levels.sv
// auto_levels -- per-channel contrast stretch for RGB888 video.
//
// Collects min/max of each colour channel over a frame's active pixels.
// During vblank a serial restoring divider turns each channel's range into
// gain = 65280/(max-min) in Q8.8. The following frame is remapped as
// out = sat((in-min)*gain >> 8). Until the first gains are computed the
// block passes video through unchanged.
//
// Ports
//   clk        pixel clock (single domain)
//   rst        asynchronous, active-high reset
//   pre_vs     frame sync in; rising edge marks a frame boundary
//   pre_de     active-pixel qualifier
//   pre_data   RGB888 in (R[23:16], G[15:8], B[7:0])
//   post_vs    pre_vs delayed 3 cycles
//   post_de    pre_de delayed 3 cycles
//   post_data  stretched RGB888 (meaningful only while post_de = 1)
//   gain_done  1-cycle pulse when a new gain/offset set becomes active
//
// Build option
//   AUTO_LEVELS_IIR_EN  when defined, each latched snapshot is blended with
//                       the previous one, (3*prev + new) >> 2, to suppress
//                       frame-to-frame flicker. Undefined: raw frame min/max.

module auto_levels #(
    parameter int MIN_RANGE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_vs,
    input  logic        pre_de,
    input  logic [23:0] pre_data,
    output logic        post_vs,
    output logic        post_de,
    output logic [23:0] post_data,
    output logic        gain_done
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int NCH    = 3;
    localparam logic [COEF_W-1:0] UNITY       = 16'h0100;
    localparam logic [COEF_W-1:0] DIVIDEND    = 16'hFF00;
    localparam logic [DATA_W:0]   MIN_RANGE_L = 9'(MIN_RANGE);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, NEXT, COMMIT} state_t;

    // Channel c: 0 = R, 1 = G, 2 = B.
    function automatic logic [DATA_W-1:0] chan(input logic [23:0] d, input int c);
        return d[8*(2-c) +: 8];
    endfunction

    // Offset removal clamped at zero.
    function automatic logic [DATA_W-1:0] sub_off(input logic [DATA_W-1:0] v,
                                                  input logic [DATA_W-1:0] off);
        return (v <= off) ? '0 : v - off;
    endfunction

    // Q8.8 gain applied, fraction truncated (keeps product bits [23:8]).
    function automatic logic [COEF_W-1:0] scale(input logic [DATA_W-1:0] d,
                                                input logic [COEF_W-1:0] g);
        logic [23:0] prod;
        prod = 24'(d) * 24'(g);
        return 16'(prod >> 8);
    endfunction

    function automatic logic [DATA_W-1:0] sat8(input logic [COEF_W-1:0] x);
        return (x[15:8] != 8'd0) ? 8'hFF : x[7:0];
    endfunction

`ifdef AUTO_LEVELS_IIR_EN
    localparam logic [DATA_W-1:0] SNAP_MIN_RST = 8'h00;
    localparam logic [DATA_W-1:0] SNAP_MAX_RST = 8'hFF;

    function automatic logic [DATA_W-1:0] blend(input logic [DATA_W-1:0] prev,
                                                input logic [DATA_W-1:0] cur);
        logic [DATA_W+1:0] acc;
        acc = 10'(prev) * 10'd3 + 10'(cur);
        return 8'(acc >> 2);
    endfunction
`else
    localparam logic [DATA_W-1:0] SNAP_MIN_RST = 8'hFF;
    localparam logic [DATA_W-1:0] SNAP_MAX_RST = 8'h00;
`endif

    state_t            state_q;
    logic              vs_q;
    logic              vs_edge;
    logic [DATA_W-1:0] stat_min_q [NCH];
    logic [DATA_W-1:0] stat_max_q [NCH];
    logic [DATA_W-1:0] snap_min_q [NCH];
    logic [DATA_W-1:0] snap_max_q [NCH];
    logic [DATA_W-1:0] snap_min_d [NCH];
    logic [DATA_W-1:0] snap_max_d [NCH];

    logic [1:0]        ch_q;
    logic [COEF_W-1:0] dvd_q;
    logic [COEF_W-1:0] quot_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] off_q;
    logic [3:0]        cnt_q;
    logic [COEF_W-1:0] pend_gain_q [NCH];
    logic [DATA_W-1:0] pend_off_q  [NCH];
    logic [COEF_W-1:0] act_gain_q  [NCH];
    logic [DATA_W-1:0] act_off_q   [NCH];
    logic              gain_done_q;

    logic [DATA_W-1:0] ld_min;
    logic [DATA_W-1:0] ld_max;
    logic [DATA_W-1:0] ld_range;
    logic              ld_unity;
    logic [DATA_W:0]   rem_sh;
    logic              div_ge;

    assign vs_edge = pre_vs & ~vs_q;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
`ifdef AUTO_LEVELS_IIR_EN
            snap_min_d[c] = blend(snap_min_q[c], stat_min_q[c]);
            snap_max_d[c] = blend(snap_max_q[c], stat_max_q[c]);
`else
            snap_min_d[c] = stat_min_q[c];
            snap_max_d[c] = stat_max_q[c];
`endif
        end
    end

    // Statistics restart on every frame edge; the snapshot is only taken when
    // the divider is free, otherwise that frame's statistics are lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                stat_min_q[c] <= 8'hFF;
                stat_max_q[c] <= 8'h00;
                snap_min_q[c] <= SNAP_MIN_RST;
                snap_max_q[c] <= SNAP_MAX_RST;
            end
        end else begin
            vs_q <= pre_vs;
            for (int c = 0; c < NCH; c++) begin
                if (vs_edge) begin
                    // A pixel in the edge cycle belongs to the new frame.
                    stat_min_q[c] <= pre_de ? chan(pre_data, c) : 8'hFF;
                    stat_max_q[c] <= pre_de ? chan(pre_data, c) : 8'h00;
                    if (state_q == IDLE) begin
                        snap_min_q[c] <= snap_min_d[c];
                        snap_max_q[c] <= snap_max_d[c];
                    end
                end else if (pre_de) begin
                    if (chan(pre_data, c) < stat_min_q[c]) stat_min_q[c] <= chan(pre_data, c);
                    if (chan(pre_data, c) > stat_max_q[c]) stat_max_q[c] <= chan(pre_data, c);
                end
            end
        end
    end

    assign ld_min   = snap_min_q[ch_q];
    assign ld_max   = snap_max_q[ch_q];
    assign ld_range = ld_max - ld_min;
    assign ld_unity = (ld_max < ld_min) || ({1'b0, ld_range} < MIN_RANGE_L);
    // Restoring step: remainder stays below the divisor, so 9 bits suffice.
    assign rem_sh   = {rem_q, dvd_q[COEF_W-1]};
    assign div_ge   = rem_sh >= {1'b0, dvs_q};

    // Gain FSM: one channel at a time, results held in pending registers and
    // made active together so a frame never sees a mixed set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= 2'd0;
            dvd_q       <= '0;
            quot_q      <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            gain_done_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                pend_gain_q[c] <= UNITY;
                pend_off_q[c]  <= '0;
                act_gain_q[c]  <= UNITY;
                act_off_q[c]   <= '0;
            end
        end else begin
            gain_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vs_edge) begin
                        ch_q    <= 2'd0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (ld_unity) begin
                        quot_q  <= UNITY;
                        off_q   <= '0;
                        state_q <= NEXT;
                    end else begin
                        dvd_q   <= DIVIDEND;
                        dvs_q   <= ld_range;
                        rem_q   <= '0;
                        quot_q  <= '0;
                        cnt_q   <= 4'd15;
                        off_q   <= ld_min;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q  <= div_ge ? 8'(rem_sh - {1'b0, dvs_q}) : rem_sh[DATA_W-1:0];
                    quot_q <= {quot_q[COEF_W-2:0], div_ge};
                    dvd_q  <= dvd_q << 1;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= NEXT;
                end
                NEXT: begin
                    pend_gain_q[ch_q] <= quot_q;
                    pend_off_q[ch_q]  <= off_q;
                    if (ch_q == 2'd2) begin
                        state_q <= COMMIT;
                    end else begin
                        ch_q    <= ch_q + 2'd1;
                        state_q <= LOAD;
                    end
                end
                COMMIT: begin
                    for (int c = 0; c < NCH; c++) begin
                        act_gain_q[c] <= pend_gain_q[c];
                        act_off_q[c]  <= pend_off_q[c];
                    end
                    gain_done_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0]   d_p0_q [NCH];
    logic [COEF_W-1:0]   p_p1_q [NCH];
    logic [3*DATA_W-1:0] data_p2_q;
    logic                vld_p0_q, vld_p1_q, vld_p2_q;
    logic                vs_p0_q, vs_p1_q, vs_p2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vs_p0_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
            vs_p2_q   <= 1'b0;
            data_p2_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                d_p0_q[c] <= '0;
                p_p1_q[c] <= '0;
            end
        end else begin
            // Stage 1: offset removal
            vld_p0_q <= pre_de;
            vs_p0_q  <= pre_vs;
            for (int c = 0; c < NCH; c++) d_p0_q[c] <= sub_off(chan(pre_data, c), act_off_q[c]);
            // Stage 2: gain multiply
            vld_p1_q <= vld_p0_q;
            vs_p1_q  <= vs_p0_q;
            for (int c = 0; c < NCH; c++) p_p1_q[c] <= scale(d_p0_q[c], act_gain_q[c]);
            // Stage 3: saturate to 8 bits
            vld_p2_q <= vld_p1_q;
            vs_p2_q  <= vs_p1_q;
            for (int c = 0; c < NCH; c++) data_p2_q[8*(2-c) +: 8] <= sat8(p_p1_q[c]);
        end
    end

    assign post_vs   = vs_p2_q;
    assign post_de   = vld_p2_q;
    assign post_data = data_p2_q;
    assign gain_done = gain_done_q;

endmodule

// File: tb/tb_auto_levels.sv
module tb_auto_levels;
    logic        clk;
    logic        rst;
    logic        pre_vs;
    logic        pre_de;
    logic [23:0] pre_data;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;
    logic        gain_done;

    auto_levels dut (
        .clk      (clk),
        .rst      (rst),
        .pre_vs   (pre_vs),
        .pre_de   (pre_de),
        .pre_data (pre_data),
        .post_vs  (post_vs),
        .post_de  (post_de),
        .post_data(post_data),
        .gain_done(gain_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: gains in force, gains waiting for vblank,
    // running min/max of pixels since the last frame edge.
    int cur_gain [3];
    int cur_off  [3];
    int pend_gain[3];
    int pend_off [3];
    int acc_min  [3];
    int acc_max  [3];
    int gd_cnt = 0;
    int gd_exp = 0;
    logic [23:0] exp_q[$];
    bit   mon_en = 1'b0;
    logic h_vs[3];
    logic h_de[3];
    logic gd_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int chan(input logic [23:0] px, input int c);
        logic [23:0] t;
        t = px >> (8 * (2 - c));
        return int'(t[7:0]);
    endfunction

    function automatic logic [23:0] model_px(input logic [23:0] px);
        logic [23:0] r;
        int v;
        int t;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            v = chan(px, c);
            if (v <= cur_off[c]) t = 0;
            else begin
                t = ((v - cur_off[c]) * cur_gain[c]) / 256;
                if (t > 255) t = 255;
            end
            r[8*(2-c) +: 8] = 8'(t);
        end
        return r;
    endfunction

    task automatic acc_reset();
        for (int c = 0; c < 3; c++) begin
            acc_min[c] = 255;
            acc_max[c] = 0;
        end
    endtask

    task automatic acc_add(input logic [23:0] px);
        for (int c = 0; c < 3; c++) begin
            if (chan(px, c) < acc_min[c]) acc_min[c] = chan(px, c);
            if (chan(px, c) > acc_max[c]) acc_max[c] = chan(px, c);
        end
    endtask

    task automatic snapshot_model();
        for (int c = 0; c < 3; c++) begin
            if (acc_max[c] < acc_min[c] || acc_max[c] - acc_min[c] < 16) begin
                pend_gain[c] = 256;
                pend_off[c]  = 0;
            end else begin
                pend_gain[c] = 65280 / (acc_max[c] - acc_min[c]);
                pend_off[c]  = acc_min[c];
            end
        end
    endtask

    task automatic commit_model();
        for (int c = 0; c < 3; c++) begin
            cur_gain[c] = pend_gain[c];
            cur_off[c]  = pend_off[c];
        end
        gd_exp++;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            cur_gain[c] = 256;
            cur_off[c]  = 0;
        end
        acc_reset();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pre_de = 1'b0;
        repeat (n) begin
            pre_data = 24'($urandom);
            tick();
        end
    endtask

    task automatic send_pix(input logic [23:0] px);
        pre_data = px;
        pre_de   = 1'b1;
        acc_add(px);
        exp_q.push_back(model_px(px));
        tick();
        pre_de = 1'b0;
    endtask

    task automatic vs_edge(input bit accept, input bit with_pix, input logic [23:0] px);
        pre_vs = 1'b1;
        if (accept) snapshot_model();
        acc_reset();
        if (with_pix) begin
            pre_data = px;
            pre_de   = 1'b1;
            acc_add(px);
            exp_q.push_back(model_px(px));
        end
        tick();
        pre_de   = 1'b0;
        pre_data = 24'($urandom);
        tick();
        pre_vs = 1'b0;
    endtask

    task automatic std_edge();
        vs_edge(1'b1, 1'b0, 24'h0);
        idle(70);
        commit_model();
        chk("gain_done_count", gd_cnt, gd_exp);
    endtask

    task automatic rand_frame(input int n, input bit full);
        int lo[3];
        int hi[3];
        logic [23:0] px;
        for (int c = 0; c < 3; c++) begin
            if (full) begin
                lo[c] = 0;
                hi[c] = 255;
            end else begin
                lo[c] = int'($urandom_range(0, 200));
                if ($urandom_range(0, 3) == 0) hi[c] = lo[c] + int'($urandom_range(0, 15));
                else                           hi[c] = lo[c] + int'($urandom_range(16, 255 - lo[c]));
            end
        end
        send_pix({8'(lo[0]), 8'(lo[1]), 8'(lo[2])});
        send_pix({8'(hi[0]), 8'(hi[1]), 8'(hi[2])});
        repeat (n) begin
            for (int c = 0; c < 3; c++) px[8*(2-c) +: 8] = 8'($urandom_range(lo[c], hi[c]));
            send_pix(px);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(4);
    endtask

    // Output monitor: 3-cycle lag of vs/de, pixel scoreboard, gain_done pulses.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                h_vs[i] = 1'b0;
                h_de[i] = 1'b0;
            end
            gd_prev = 1'b0;
        end else if (mon_en) begin
            chk("post_vs_lag", post_vs, h_vs[2]);
            chk("post_de_lag", post_de, h_de[2]);
            if (post_de === 1'b1) begin
                chk("scoreboard_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("post_data", post_data, exp_q.pop_front());
            end
            if (gain_done === 1'b1) begin
                gd_cnt++;
                chk("gain_done_width", gd_prev, 0);
            end
            gd_prev = gain_done;
            h_vs[2] = h_vs[1]; h_vs[1] = h_vs[0]; h_vs[0] = pre_vs;
            h_de[2] = h_de[1]; h_de[1] = h_de[0]; h_de[0] = pre_de;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst      = 1'b1;
        pre_vs   = 1'b0;
        pre_de   = 1'b0;
        pre_data = 24'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_post_vs", post_vs, 0);
        chk("rst_post_de", post_de, 0);
        chk("rst_post_data", post_data, 0);
        chk("rst_gain_done", gain_done, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Frame after reset: unity pass-through of a constant colour.
        std_edge();
        repeat (24) begin
            send_pix(24'h405060);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);

        // Red sweep 50..150 with constant G/B, then directed red values.
        std_edge();
        send_pix({8'd50, 8'h30, 8'h90});
        send_pix({8'd150, 8'h30, 8'h90});
        repeat (30) send_pix({8'($urandom_range(50, 150)), 8'h30, 8'h90});
        idle(4);
        std_edge();
        send_pix({8'd100, 8'h30, 8'h90});
        send_pix({8'd150, 8'h30, 8'h90});
        send_pix({8'd40, 8'h30, 8'h90});
        send_pix({8'd200, 8'h30, 8'h90});
        send_pix({8'd50, 8'h30, 8'h90});
        send_pix({8'd51, 8'h30, 8'h90});
        repeat (12) send_pix(24'($urandom));
        idle(4);

        // Random ranges per channel; one edge carries an active pixel.
        for (int i = 0; i < 4; i++) begin
            rand_frame(24, 1'b0);
            vs_edge(1'b1, i == 1, 24'h01FE80);
            idle(70);
            commit_model();
            chk("gain_done_count", gd_cnt, gd_exp);
        end

        // Flat frame collapses to unity gain.
        repeat (20) send_pix(24'h808080);
        idle(4);
        std_edge();
        rand_frame(20, 1'b1);
        std_edge();
        rand_frame(20, 1'b0);

        // Second edge while the divider is busy: its statistics are dropped.
        vs_edge(1'b1, 1'b0, 24'h0);
        idle(14);
        send_pix(24'h000000);
        send_pix(24'hFFFFFF);
        send_pix(24'h00FF00);
        send_pix(24'hFF00FF);
        vs_edge(1'b0, 1'b0, 24'h0);
        idle(70);
        commit_model();
        chk("gain_done_count_busy", gd_cnt, gd_exp);
        rand_frame(20, 1'b1);
        std_edge();
        rand_frame(20, 1'b0);
        std_edge();

        // Reset while channel G is dividing.
        send_pix({8'd50, 8'd10, 8'd0});
        send_pix({8'd150, 8'd200, 8'd255});
        repeat (10) send_pix({8'($urandom_range(50, 150)), 8'($urandom_range(10, 200)), 8'($urandom)});
        idle(4);
        vs_edge(1'b1, 1'b0, 24'h0);
        idle(26);
        #3 rst = 1'b1;
        #1;
        chk("midrst_post_vs", post_vs, 0);
        chk("midrst_post_de", post_de, 0);
        chk("midrst_post_data", post_data, 0);
        chk("midrst_gain_done", gain_done, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rand_frame(16, 1'b1);
        idle(70);
        chk("gain_done_after_rst", gd_cnt, gd_exp);
        std_edge();
        rand_frame(20, 1'b1);

        idle(8);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
